// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared types and default constants for the elevator call dispatcher
package elevator_pkg;

    localparam int DEF_NUM_FLOORS  = 16;
    localparam int DEF_FLOOR_W     = 4;
    localparam int DEF_DOOR_CYCLES = 8;

    typedef logic [DEF_FLOOR_W-1:0] floor_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SELECT   = 3'd1,
        DISPATCH = 3'd2,
        ARRIVE   = 3'd3,
        DOOR     = 3'd4
    } state_t;

endpackage

// File: rtl/elevator_scan_picker.sv
// rtl/elevator_scan_picker.sv - combinational SCAN pick of the next floor to serve
module elevator_scan_picker
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = DEF_NUM_FLOORS,
    parameter int FLOOR_W    = DEF_FLOOR_W
) (
    input  logic [NUM_FLOORS-1:0] i_pending,
    input  logic [FLOOR_W-1:0]    i_cur_floor,
    input  logic                  i_dir_up,
    output logic                  o_found,
    output logic [FLOOR_W-1:0]    o_next_floor,
    output logic                  o_next_dir
);

    logic               w_above_found;
    logic               w_below_found;
    logic [FLOOR_W-1:0] w_above;
    logic [FLOOR_W-1:0] w_below;

    // Nearest call above is the lowest set bit above; nearest below is the highest set bit below.
    always_comb begin
        w_above_found = 1'b0;
        w_above       = '0;
        w_below_found = 1'b0;
        w_below       = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (i_pending[i] && (i > int'(i_cur_floor))) begin
                w_above_found = 1'b1;
                w_above       = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i_pending[i] && (i < int'(i_cur_floor))) begin
                w_below_found = 1'b1;
                w_below       = FLOOR_W'(i);
            end
        end
    end

    always_comb begin
        o_found      = 1'b0;
        o_next_floor = '0;
        o_next_dir   = i_dir_up;
        if (i_dir_up) begin
            if (w_above_found) begin
                o_found      = 1'b1;
                o_next_floor = w_above;
                o_next_dir   = 1'b1;
            end else if (w_below_found) begin
                o_found      = 1'b1;
                o_next_floor = w_below;
                o_next_dir   = 1'b0;
            end
        end else begin
            if (w_below_found) begin
                o_found      = 1'b1;
                o_next_floor = w_below;
                o_next_dir   = 1'b0;
            end else if (w_above_found) begin
                o_found      = 1'b1;
                o_next_floor = w_above;
                o_next_dir   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/elevator_call_dispatcher.sv
// rtl/elevator_call_dispatcher.sv - SCAN call dispatcher with call lamps and door dwell timer
// Optional fire recall to floor 0 enabled by defining FIRE_RECALL_EN.
module elevator_call_dispatcher
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS  = DEF_NUM_FLOORS,
    parameter int FLOOR_W     = DEF_FLOOR_W,
    parameter int DOOR_CYCLES = DEF_DOOR_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] i_call_req,
    input  logic [FLOOR_W-1:0]    i_cur_floor,
    input  logic                  i_arrived,
    input  logic                  i_hold,
`ifdef FIRE_RECALL_EN
    input  logic                  i_fire_recall,
`endif
    output logic [FLOOR_W-1:0]    o_target_floor,
    output logic                  o_target_valid,
    output logic                  o_dir_up,
    output logic [NUM_FLOORS-1:0] o_pending,
    output logic                  o_door_open,
    output logic                  o_idle
);

    localparam int CNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DOOR_LOAD = CNT_W'(DOOR_CYCLES - 1);

    state_t                  r_state;
    logic [NUM_FLOORS-1:0]   r_pending;
    logic [FLOOR_W-1:0]      r_target_floor;
    logic [FLOOR_W-1:0]      r_serve_floor;
    logic                    r_target_valid;
    logic                    r_dir_up;
    logic                    r_door_open;
    logic [CNT_W-1:0]        r_door_cnt;
`ifdef FIRE_RECALL_EN
    logic                    r_recall;
`endif

    logic                    w_fire;
    logic                    w_cur_valid;
    logic [NUM_FLOORS-1:0]   w_cur_onehot;
    logic [NUM_FLOORS-1:0]   w_clear_mask;
    logic [NUM_FLOORS-1:0]   w_absorb_mask;
    logic [NUM_FLOORS-1:0]   w_pending_nxt;
    logic                    w_here_pending;
    logic                    w_door_call;
    logic                    w_found;
    logic [FLOOR_W-1:0]      w_next_floor;
    logic                    w_next_dir;

`ifdef FIRE_RECALL_EN
    assign w_fire = i_fire_recall;
`else
    assign w_fire = 1'b0;
`endif

    assign w_cur_valid    = int'(i_cur_floor) < NUM_FLOORS;
    assign w_cur_onehot   = w_cur_valid ? (NUM_FLOORS'(1) << i_cur_floor) : '0;
    assign w_here_pending = |(r_pending & w_cur_onehot);
    assign w_door_call    = |(i_call_req & w_cur_onehot);

    // Clearing the served floor outranks a same-cycle call to it; calls at an open door are absorbed.
    assign w_clear_mask  = (r_state == ARRIVE) ? (NUM_FLOORS'(1) << r_serve_floor) : '0;
    assign w_absorb_mask = (r_state == DOOR) ? w_cur_onehot : '0;
    assign w_pending_nxt = w_fire ? '0
                                  : ((r_pending | (i_call_req & ~w_absorb_mask)) & ~w_clear_mask);

    elevator_scan_picker #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_picker (
        .i_pending    (r_pending),
        .i_cur_floor  (i_cur_floor),
        .i_dir_up     (r_dir_up),
        .o_found      (w_found),
        .o_next_floor (w_next_floor),
        .o_next_dir   (w_next_dir)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_pending      <= '0;
            r_target_floor <= '0;
            r_serve_floor  <= '0;
            r_target_valid <= 1'b0;
            r_dir_up       <= 1'b1;
            r_door_open    <= 1'b0;
            r_door_cnt     <= '0;
`ifdef FIRE_RECALL_EN
            r_recall       <= 1'b0;
`endif
        end else begin
            r_pending <= w_pending_nxt;
`ifdef FIRE_RECALL_EN
            if (i_fire_recall) begin
                r_recall       <= 1'b1;
                r_target_floor <= '0;
                r_serve_floor  <= '0;
                r_dir_up       <= 1'b0;
                if (r_recall && (r_state == DOOR)) begin
                    r_door_open    <= 1'b1;
                    r_target_valid <= 1'b0;
                end else if (r_recall && (r_state == DISPATCH) && i_arrived && (i_cur_floor == '0)) begin
                    r_state        <= DOOR;
                    r_door_open    <= 1'b1;
                    r_target_valid <= 1'b0;
                end else begin
                    r_state        <= DISPATCH;
                    r_target_valid <= 1'b1;
                    r_door_open    <= 1'b0;
                end
            end else if (r_recall) begin
                r_recall       <= 1'b0;
                r_state        <= IDLE;
                r_target_valid <= 1'b0;
                r_door_open    <= 1'b0;
            end else
`endif
            if (!w_cur_valid) begin
                r_state        <= IDLE;
                r_target_valid <= 1'b0;
                r_door_open    <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_target_valid <= 1'b0;
                        if (w_here_pending) begin
                            r_serve_floor <= i_cur_floor;
                            r_state       <= ARRIVE;
                        end else if (|r_pending) begin
                            r_state <= SELECT;
                        end
                    end
                    SELECT: begin
                        if (w_found) begin
                            r_target_floor <= w_next_floor;
                            r_serve_floor  <= w_next_floor;
                            r_dir_up       <= w_next_dir;
                            r_target_valid <= 1'b1;
                            r_state        <= DISPATCH;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                    DISPATCH: begin
                        if (i_arrived && (i_cur_floor == r_target_floor)) begin
                            r_state <= ARRIVE;
                        end
                    end
                    ARRIVE: begin
                        r_target_valid <= 1'b0;
                        r_door_cnt     <= DOOR_LOAD;
                        r_door_open    <= 1'b1;
                        r_state        <= DOOR;
                    end
                    DOOR: begin
                        if (w_door_call) begin
                            r_door_cnt <= DOOR_LOAD;
                        end else if (!i_hold) begin
                            if (r_door_cnt == '0) begin
                                r_door_open <= 1'b0;
                                r_state     <= IDLE;
                            end else begin
                                r_door_cnt <= r_door_cnt - 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state        <= IDLE;
                        r_target_valid <= 1'b0;
                        r_door_open    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_target_floor = r_target_floor;
    assign o_target_valid = r_target_valid;
    assign o_dir_up       = r_dir_up;
    assign o_pending      = r_pending;
    assign o_door_open    = r_door_open;
    assign o_idle         = (r_state == IDLE) && (r_pending == '0);

endmodule

// File: tb/tb_elevator_call_dispatcher.sv
// tb/tb_elevator_call_dispatcher.sv - directed self-checking bench for elevator_call_dispatcher
module tb_elevator_call_dispatcher;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] call_req;
    logic [3:0]  cur_floor;
    logic        arrived;
    logic        hold;
`ifdef FIRE_RECALL_EN
    logic        fire;
`endif
    logic [3:0]  target_floor;
    logic        target_valid;
    logic        dir_up;
    logic [15:0] pending;
    logic        door_open;
    logic        idle;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    elevator_call_dispatcher dut (
        .clk            (clk),
        .reset          (reset),
        .i_call_req     (call_req),
        .i_cur_floor    (cur_floor),
        .i_arrived      (arrived),
        .i_hold         (hold),
`ifdef FIRE_RECALL_EN
        .i_fire_recall  (fire),
`endif
        .o_target_floor (target_floor),
        .o_target_valid (target_valid),
        .o_dir_up       (dir_up),
        .o_pending      (pending),
        .o_door_open    (door_open),
        .o_idle         (idle)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset    = 1'b0;
        call_req = '0;
        arrived  = 1'b0;
        hold     = 1'b0;
`ifdef FIRE_RECALL_EN
        fire     = 1'b0;
`endif
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    // Arrive at a floor, let the door cycle, stop when the next dispatch is up or the car is idle.
    task automatic serve_floor(input logic [3:0] f, output bit timed_out);
        bit opened;
        bit settled;
        opened  = 1'b0;
        settled = 1'b0;
        cur_floor = f;
        arrived   = 1'b1;
        tick();
        arrived = 1'b0;
        for (int n = 0; n < 5 && !opened; n++) begin
            tick();
            if (door_open) opened = 1'b1;
        end
        for (int n = 0; n < 60 && opened && !settled; n++) begin
            tick();
            if (!door_open && (target_valid || idle)) settled = 1'b1;
        end
        timed_out = !settled;
    endtask

    task automatic test_reset;
        reset = 1'b0; call_req = '0; cur_floor = 4'd2; arrived = 0; hold = 0;
`ifdef FIRE_RECALL_EN
        fire = 1'b0;
`endif
        repeat (2) tick();
        checks++; if (target_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", target_valid); end
        checks++; if (target_floor !== 4'd0) begin errors++; $display("FAIL reset_target: got %0d want 0", target_floor); end
        checks++; if (dir_up !== 1'b1) begin errors++; $display("FAIL reset_dir: got %0b want 1", dir_up); end
        checks++; if (pending !== 16'h0) begin errors++; $display("FAIL reset_pending: got %h want 0000", pending); end
        checks++; if (door_open !== 1'b0) begin errors++; $display("FAIL reset_door: got %0b want 0", door_open); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %0b want 1", idle); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_call;
        int n;
        cur_floor = 4'd2;
        call_req  = 16'h0200;
        tick();
        call_req = '0;
        checks++; if (pending !== 16'h0200) begin errors++; $display("FAIL call_latch: got %h want 0200", pending); end
        tick();
        checks++; if (target_valid !== 1'b0) begin errors++; $display("FAIL early_valid: got %0b want 0", target_valid); end
        tick();
        checks++; if (target_valid !== 1'b1 || target_floor !== 4'd9 || dir_up !== 1'b1)
            begin errors++; $display("FAIL dispatch9: got v=%0b t=%0d up=%0b want v=1 t=9 up=1", target_valid, target_floor, dir_up); end
        cur_floor = 4'd9;
        arrived   = 1'b1;
        tick();
        arrived = 1'b0;
        tick();
        checks++; if (pending !== 16'h0 || door_open !== 1'b1 || target_valid !== 1'b0)
            begin errors++; $display("FAIL arrive9: got p=%h door=%0b v=%0b want p=0000 door=1 v=0", pending, door_open, target_valid); end
        n = 1;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (door_open) n++; else break;
        end
        checks++; if (n != 8) begin errors++; $display("FAIL door_dwell: got %0d cycles want 8", n); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL idle_after_door: got %0b want 1", idle); end
    endtask

    task automatic test_scan;
        bit to;
        cur_floor = 4'd5;
        call_req  = 16'h1088;
        tick();
        call_req = '0;
        repeat (2) tick();
        checks++; if (target_floor !== 4'd7 || dir_up !== 1'b1 || target_valid !== 1'b1)
            begin errors++; $display("FAIL scan_first: got t=%0d up=%0b v=%0b want t=7 up=1 v=1", target_floor, dir_up, target_valid); end
        serve_floor(4'd7, to);
        checks++; if (to || target_floor !== 4'd12 || dir_up !== 1'b1)
            begin errors++; $display("FAIL scan_second: got t=%0d up=%0b to=%0b want t=12 up=1", target_floor, dir_up, to); end
        serve_floor(4'd12, to);
        checks++; if (to || target_floor !== 4'd3 || dir_up !== 1'b0)
            begin errors++; $display("FAIL scan_reverse: got t=%0d up=%0b to=%0b want t=3 up=0", target_floor, dir_up, to); end
        serve_floor(4'd3, to);
        checks++; if (to || idle !== 1'b1 || pending !== 16'h0)
            begin errors++; $display("FAIL scan_done: got idle=%0b p=%h to=%0b want idle=1 p=0000", idle, pending, to); end
    endtask

    task automatic test_call_here;
        bit saw_valid;
        saw_valid = 1'b0;
        cur_floor = 4'd4;
        call_req  = 16'h0010;
        tick();
        call_req = '0;
        tick();
        checks++; if (door_open !== 1'b0 || target_valid !== 1'b0)
            begin errors++; $display("FAIL here_arrive: got door=%0b v=%0b want door=0 v=0", door_open, target_valid); end
        tick();
        checks++; if (door_open !== 1'b1 || pending !== 16'h0)
            begin errors++; $display("FAIL here_door: got door=%0b p=%h want door=1 p=0000", door_open, pending); end
        for (int k = 0; k < 30 && !idle; k++) begin
            tick();
            if (target_valid) saw_valid = 1'b1;
        end
        checks++; if (saw_valid || idle !== 1'b1)
            begin errors++; $display("FAIL here_no_dispatch: got saw_valid=%0b idle=%0b want 0 and 1", saw_valid, idle); end
    endtask

    task automatic test_hold;
        bit all_open;
        int n;
        all_open  = 1'b1;
        cur_floor = 4'd6;
        call_req  = 16'h0040;
        tick();
        call_req = '0;
        repeat (2) tick();
        hold = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (!door_open) all_open = 1'b0;
        end
        checks++; if (!all_open) begin errors++; $display("FAIL hold_door: got door closed under hold want open"); end
        hold = 1'b0;
        n = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            n++;
            if (!door_open) break;
        end
        checks++; if (n != 8) begin errors++; $display("FAIL hold_release: got close after %0d want 8", n); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL hold_idle: got %0b want 1", idle); end
    endtask

    task automatic test_absorb;
        int n;
        cur_floor = 4'd6;
        call_req  = 16'h0040;
        tick();
        call_req = '0;
        repeat (2) tick();
        repeat (3) tick();
        call_req = 16'h0040;
        tick();
        call_req = '0;
        checks++; if (pending !== 16'h0 || door_open !== 1'b1)
            begin errors++; $display("FAIL absorb_pending: got p=%h door=%0b want p=0000 door=1", pending, door_open); end
        n = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            n++;
            if (!door_open) break;
        end
        checks++; if (n != 8) begin errors++; $display("FAIL absorb_reload: got close after %0d want 8", n); end
    endtask

    task automatic test_mismatch_and_reset;
        cur_floor = 4'd12;
        call_req  = 16'h4400;
        tick();
        call_req = '0;
        repeat (2) tick();
        checks++; if (target_floor !== 4'd10 || dir_up !== 1'b0 || target_valid !== 1'b1)
            begin errors++; $display("FAIL dispatch10: got t=%0d up=%0b v=%0b want t=10 up=0 v=1", target_floor, dir_up, target_valid); end
        cur_floor = 4'd8;
        arrived   = 1'b1;
        tick();
        arrived = 1'b0;
        repeat (2) tick();
        checks++; if (target_valid !== 1'b1 || target_floor !== 4'd10 || door_open !== 1'b0)
            begin errors++; $display("FAIL mismatch_ignored: got v=%0b t=%0d door=%0b want v=1 t=10 door=0", target_valid, target_floor, door_open); end
        #2 reset = 1'b0;
        #1;
        checks++; if (target_valid !== 1'b0 || target_floor !== 4'd0 || dir_up !== 1'b1 || pending !== 16'h0 || idle !== 1'b1 || door_open !== 1'b0)
            begin errors++; $display("FAIL async_reset: got v=%0b t=%0d up=%0b p=%h idle=%0b door=%0b want 0 0 1 0000 1 0",
                target_valid, target_floor, dir_up, pending, idle, door_open); end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_clear_race;
        cur_floor = 4'd1;
        call_req  = 16'h0020;
        tick();
        call_req = '0;
        repeat (2) tick();
        cur_floor = 4'd5;
        arrived   = 1'b1;
        tick();
        arrived  = 1'b0;
        call_req = 16'h0024;
        tick();
        call_req = '0;
        checks++; if (pending !== 16'h0004) begin errors++; $display("FAIL clear_race: got %h want 0004", pending); end
        do_reset();
    endtask

`ifdef FIRE_RECALL_EN
    task automatic test_fire_recall;
        bit all_open;
        all_open  = 1'b1;
        cur_floor = 4'd7;
        call_req  = 16'h0810;
        tick();
        call_req = '0;
        fire     = 1'b1;
        tick();
        checks++; if (pending !== 16'h0 || target_floor !== 4'd0 || target_valid !== 1'b1 || dir_up !== 1'b0)
            begin errors++; $display("FAIL fire_dispatch: got p=%h t=%0d v=%0b up=%0b want 0000 0 1 0", pending, target_floor, target_valid, dir_up); end
        call_req = 16'h0200;
        tick();
        call_req = '0;
        checks++; if (pending !== 16'h0) begin errors++; $display("FAIL fire_ignore_call: got %h want 0000", pending); end
        cur_floor = 4'd0;
        arrived   = 1'b1;
        tick();
        arrived = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (!door_open) all_open = 1'b0;
            tick();
        end
        checks++; if (!all_open) begin errors++; $display("FAIL fire_door_held: got door closed want open"); end
        fire = 1'b0;
        tick();
        checks++; if (door_open !== 1'b0 || idle !== 1'b1)
            begin errors++; $display("FAIL fire_release: got door=%0b idle=%0b want 0 1", door_open, idle); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_call();
        test_scan();
        test_call_here();
        test_hold();
        test_absorb();
        test_mismatch_and_reset();
        test_clear_race();
`ifdef FIRE_RECALL_EN
        test_fire_recall();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
